// File: rtl/dp_tx_crc_multi_ch_checker_if.sv
// Video/reference/status bundle for the DP TX per-channel CRC-16 frame checker.
// The master side drives video beats and SDP references; the slave side is the checker.
interface dp_tx_crc_multi_ch_checker_if #(
  parameter int NUM_CH = 3,
  parameter int COMP_W = 64,
  parameter int CNT_W  = 16
);
  logic                     crc_en;
  logic                     frame_start;
  logic                     frame_end;
  logic                     video_valid;
  logic [NUM_CH*COMP_W-1:0] video_data;
  logic                     ref_valid;
  logic [NUM_CH*16-1:0]     ref_crc;
  logic                     err_clr;
  logic [NUM_CH*16-1:0]     crc_out;
  logic                     crc_done;
  logic                     crc_err;
  logic [NUM_CH-1:0]        err_mask;
  logic                     ref_timeout;
  logic                     frame_abort;
  logic [CNT_W-1:0]         mismatch_cnt;
  logic                     scalar_crc_err;

  modport master (
    output crc_en, frame_start, frame_end, video_valid, video_data, ref_valid, ref_crc, err_clr,
    input  crc_out, crc_done, crc_err, err_mask, ref_timeout, frame_abort, mismatch_cnt, scalar_crc_err
  );

  modport slave (
    input  crc_en, frame_start, frame_end, video_valid, video_data, ref_valid, ref_crc, err_clr,
    output crc_out, crc_done, crc_err, err_mask, ref_timeout, frame_abort, mismatch_cnt, scalar_crc_err
  );
endinterface

// File: rtl/dp_tx_crc_multi_ch_checker.sv
// Per-colour-component CRC-16 (poly 0x1021) frame checker for DP TX: accumulates one CRC
// per channel per frame, compares with the SDP reference and escalates repeated failures.
module dp_tx_crc_multi_ch_checker #(
  parameter int NUM_CH      = 3,
  parameter int COMP_W      = 64,
  parameter int REF_TIMEOUT = 1024,
  parameter int ERR_THRESH  = 2,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dp_tx_crc_multi_ch_checker_if.slave bus
);
  localparam int CRC_W = NUM_CH * 16;
  localparam int TMR_W = $clog2(REF_TIMEOUT + 1);
  localparam int CON_W = $clog2(ERR_THRESH + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_TIMEOUT - 1);
  localparam logic [CON_W-1:0] CON_MAX  = CON_W'(ERR_THRESH);

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_REF, COMPARE} state_t;

  // One beat of one channel, MSB first, no reflection.
  function automatic logic [15:0] crc16_fold(input logic [15:0] crc_in, input logic [COMP_W-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = COMP_W - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  state_t             state_q;
  logic [CRC_W-1:0]   crc_q, crc_out_q, ref_q;
  logic               ref_held_q;
  logic [TMR_W-1:0]   timer_q;
  logic [CON_W-1:0]   consec_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               scalar_q, done_q, err_q, tmo_q, abort_q;
  logic [NUM_CH-1:0]  mask_q;

  logic [CRC_W-1:0]   crc_run_d, crc_init_d;
  logic [NUM_CH-1:0]  mask_d;
  logic               mism_d, start_d;
  logic [CON_W-1:0]   consec_inc_d;
  logic [CNT_W-1:0]   cnt_inc_d;

  always_comb begin
    crc_run_d  = crc_q;
    crc_init_d = '0;
    mask_d     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.video_valid) begin
        crc_run_d[c*16 +: 16]  = crc16_fold(crc_q[c*16 +: 16], bus.video_data[c*COMP_W +: COMP_W]);
        crc_init_d[c*16 +: 16] = crc16_fold(16'h0000, bus.video_data[c*COMP_W +: COMP_W]);
      end
      mask_d[c] = (crc_out_q[c*16 +: 16] != ref_q[c*16 +: 16]);
    end
    mism_d       = |mask_d;
    consec_inc_d = (consec_q == CON_MAX) ? consec_q : consec_q + CON_W'(1);
    // A clear in the same cycle as a mismatch restarts the count at one.
    cnt_inc_d    = bus.err_clr ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    start_d      = bus.frame_start & bus.crc_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      crc_q      <= '0;
      crc_out_q  <= '0;
      ref_q      <= '0;
      ref_held_q <= 1'b0;
      timer_q    <= '0;
      consec_q   <= '0;
      cnt_q      <= '0;
      scalar_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mask_q     <= '0;
      tmo_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      abort_q <= 1'b0;
      if (bus.err_clr) begin
        cnt_q    <= '0;
        scalar_q <= 1'b0;
      end
      case (state_q)
        IDLE, COMPARE: begin
          if (state_q == COMPARE) begin
            done_q <= 1'b1;
            err_q  <= mism_d;
            mask_q <= mask_d;
            if (mism_d) begin
              consec_q <= consec_inc_d;
              cnt_q    <= cnt_inc_d;
              if (consec_inc_d == CON_MAX) scalar_q <= 1'b1;
            end else begin
              consec_q <= '0;
            end
          end
          // References seen outside a frame are dropped unless they ride on the start beat.
          ref_held_q <= 1'b0;
          state_q    <= IDLE;
          if (start_d) begin
            crc_q <= crc_init_d;
            if (bus.ref_valid) begin
              ref_q      <= bus.ref_crc;
              ref_held_q <= 1'b1;
            end
            if (bus.frame_end) begin
              crc_out_q <= crc_init_d;
              timer_q   <= '0;
              state_q   <= WAIT_REF;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (bus.ref_valid) begin
            ref_q      <= bus.ref_crc;
            ref_held_q <= 1'b1;
          end
          if (bus.frame_end) begin
            crc_out_q <= crc_run_d;
            timer_q   <= '0;
            state_q   <= WAIT_REF;
          end else if (bus.frame_start) begin
            abort_q <= 1'b1;
            crc_q   <= crc_init_d;
            if (!bus.ref_valid) ref_held_q <= 1'b0;
          end else begin
            crc_q <= crc_run_d;
          end
        end
        WAIT_REF: begin
          timer_q <= timer_q + TMR_W'(1);
          if (bus.frame_start) begin
            tmo_q      <= 1'b1;
            ref_held_q <= 1'b0;
            if (bus.crc_en) begin
              crc_q   <= crc_init_d;
              state_q <= ACCUM;
              if (bus.ref_valid) begin
                ref_q      <= bus.ref_crc;
                ref_held_q <= 1'b1;
              end
            end else begin
              state_q <= IDLE;
            end
          end else if (ref_held_q || bus.ref_valid) begin
            if (bus.ref_valid) ref_q <= bus.ref_crc;
            ref_held_q <= 1'b1;
            state_q    <= COMPARE;
          end else if (timer_q == TMR_LAST) begin
            tmo_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.crc_out        = crc_out_q;
  assign bus.crc_done       = done_q;
  assign bus.crc_err        = err_q;
  assign bus.err_mask       = mask_q;
  assign bus.ref_timeout    = tmo_q;
  assign bus.frame_abort    = abort_q;
  assign bus.mismatch_cnt   = cnt_q;
  assign bus.scalar_crc_err = scalar_q;
endmodule

// File: tb/tb_dp_tx_crc_multi_ch_checker.sv
// Randomised directed bench for the DP TX multi-channel CRC checker; expected CRCs come from
// polynomial long division and expected counters from a frame-level model.
module tb_dp_tx_crc_multi_ch_checker;
  localparam int NUM_CH = 3, COMP_W = 8, REF_TIMEOUT = 8, ERR_THRESH = 2, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dp_tx_crc_multi_ch_checker_if #(.NUM_CH(NUM_CH), .COMP_W(COMP_W), .CNT_W(CNT_W)) bus();

  dp_tx_crc_multi_ch_checker #(
    .NUM_CH(NUM_CH), .COMP_W(COMP_W), .REF_TIMEOUT(REF_TIMEOUT),
    .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int consec = 0;
  int mcnt   = 0;
  bit scalar = 1'b0;
  logic [23:0] beats[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1 over the channel's bit stream.
  function automatic logic [15:0] model_crc(input int c);
    logic [16:0] rem;
    rem = '0;
    foreach (beats[k]) begin
      for (int i = COMP_W - 1; i >= 0; i--) begin
        rem = {rem[15:0], beats[k][c*COMP_W + i]};
        if (rem[16]) rem = rem ^ 17'h11021;
      end
    end
    for (int i = 0; i < 16; i++) begin
      rem = {rem[15:0], 1'b0};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  function automatic logic [47:0] model_all();
    logic [47:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*16 +: 16] = model_crc(c);
    return r;
  endfunction

  task automatic model_compare(input bit mism);
    if (mism) begin
      if (consec < ERR_THRESH) consec++;
      if (consec == ERR_THRESH) scalar = 1'b1;
      if (mcnt < 65535) mcnt++;
    end else begin
      consec = 0;
    end
  endtask

  task automatic drive(input bit fs, input bit fe, input bit vv, input logic [23:0] d);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.video_valid = vv;
    bus.video_data  = d;
  endtask

  task automatic clr_in();
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    bus.ref_valid = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_mismatch_cnt"}, 64'(bus.mismatch_cnt), 64'(mcnt));
    chk({tag, "_scalar"}, 64'(bus.scalar_crc_err), 64'(scalar));
  endtask

  // ref_pos < beats: reference on that beat; otherwise it arrives dly clocks after frame end.
  task automatic run_frame(input int ref_pos, input int dly, input logic [2:0] bad);
    logic [47:0] expc, refv;
    int n;
    bit mism;
    n    = beats.size();
    expc = model_all();
    refv = expc;
    for (int c = 0; c < NUM_CH; c++)
      if (bad[c]) refv[c*16 +: 16] = expc[c*16 +: 16] ^ 16'($urandom_range(1, 65535));
    for (int b = 0; b < n; b++) begin
      drive(b == 0, b == n - 1, 1'b1, beats[b]);
      bus.crc_en    = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.ref_valid = (ref_pos == b);
      bus.ref_crc   = refv;
      tick();
      if (b != n - 1 && $urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 1'b0, 24'($urandom));
        bus.ref_valid = 1'b0;
        tick();
      end
    end
    clr_in();
    bus.crc_en = 1'b1;
    chk("crc_out", 64'(bus.crc_out), 64'(expc));
    if (ref_pos >= n) begin
      for (int k = 0; k < dly; k++) begin
        tick();
        chk("done_while_waiting", 64'(bus.crc_done), 64'(0));
      end
      bus.ref_valid = 1'b1;
      bus.ref_crc   = refv;
      tick();
      bus.ref_valid = 1'b0;
    end else begin
      tick();
    end
    chk("done_too_early", 64'(bus.crc_done), 64'(0));
    tick();
    mism = |bad;
    model_compare(mism);
    chk("crc_done", 64'(bus.crc_done), 64'(1));
    chk("crc_err", 64'(bus.crc_err), 64'(mism));
    chk("err_mask", 64'(bus.err_mask), 64'(bad));
    chk_counters("cmp");
    tick();
    chk("done_pulse_width", 64'(bus.crc_done), 64'(0));
  endtask

  task automatic rand_beats(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(24'($urandom));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_crc_out"}, 64'(bus.crc_out), 64'(0));
    chk({tag, "_crc_done"}, 64'(bus.crc_done), 64'(0));
    chk({tag, "_crc_err"}, 64'(bus.crc_err), 64'(0));
    chk({tag, "_err_mask"}, 64'(bus.err_mask), 64'(0));
    chk({tag, "_ref_timeout"}, 64'(bus.ref_timeout), 64'(0));
    chk({tag, "_frame_abort"}, 64'(bus.frame_abort), 64'(0));
    chk({tag, "_mismatch_cnt"}, 64'(bus.mismatch_cnt), 64'(0));
    chk({tag, "_scalar"}, 64'(bus.scalar_crc_err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] expc, stale;
    logic [23:0] d;
    clr_in();
    bus.crc_en  = 1'b0;
    bus.ref_crc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.crc_en = 1'b1;

    // Single-beat frame, reference on the start/end beat.
    beats.delete();
    beats.push_back(24'h010101);
    run_frame(0, 0, 3'b000);
    chk("crc_out_literal", 64'(bus.crc_out), 64'h1021_1021_1021);

    // Same frame, reference after end with channel 1 wrong.
    run_frame(1, 0, 3'b010);
    chk("single_mismatch_scalar", 64'(bus.scalar_crc_err), 64'(0));

    // Second consecutive mismatch raises scalar.
    rand_beats(3);
    run_frame(3, 2, 3'b001);
    chk("scalar_raised", 64'(bus.scalar_crc_err), 64'(1));

    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    mcnt   = 0;
    scalar = 1'b0;
    chk_counters("err_clr");

    // A matching frame must reset the consecutive count.
    rand_beats(2);
    run_frame(1, 0, 3'b000);
    rand_beats(2);
    run_frame(2, 1, 3'b100);
    chk("scalar_after_match", 64'(bus.scalar_crc_err), 64'(0));

    // Missing reference: timeout exactly REF_TIMEOUT clocks after WAIT_REF entry.
    rand_beats(2);
    drive(1'b1, 1'b0, 1'b1, beats[0]);
    tick();
    drive(1'b0, 1'b1, 1'b1, beats[1]);
    tick();
    clr_in();
    chk("timeout_crc_out", 64'(bus.crc_out), 64'(model_all()));
    for (int k = 1; k <= REF_TIMEOUT; k++) begin
      tick();
      chk($sformatf("ref_timeout_clk%0d", k), 64'(bus.ref_timeout), 64'(k == REF_TIMEOUT));
      chk($sformatf("timeout_no_done_clk%0d", k), 64'(bus.crc_done), 64'(0));
    end
    tick();
    chk("ref_timeout_pulse", 64'(bus.ref_timeout), 64'(0));
    chk_counters("timeout");

    // Abort mid-frame with a stale reference captured beforehand.
    drive(1'b1, 1'b0, 1'b1, 24'($urandom));
    tick();
    stale = 48'({$urandom(), $urandom()});
    drive(1'b0, 1'b0, 1'b1, 24'($urandom));
    bus.ref_valid = 1'b1;
    bus.ref_crc   = stale;
    tick();
    bus.ref_valid = 1'b0;
    beats.delete();
    d = 24'($urandom);
    beats.push_back(d);
    drive(1'b1, 1'b0, 1'b1, d);
    tick();
    chk("frame_abort", 64'(bus.frame_abort), 64'(1));
    d = 24'($urandom);
    beats.push_back(d);
    drive(1'b0, 1'b1, 1'b1, d);
    tick();
    clr_in();
    expc = model_all();
    chk("frame_abort_pulse", 64'(bus.frame_abort), 64'(0));
    chk("abort_crc_out", 64'(bus.crc_out), 64'(expc));
    tick();
    tick();
    chk("stale_ref_discarded", 64'(bus.crc_done), 64'(0));
    bus.ref_valid = 1'b1;
    bus.ref_crc   = expc;
    tick();
    bus.ref_valid = 1'b0;
    tick();
    model_compare(1'b0);
    chk("abort_done", 64'(bus.crc_done), 64'(1));
    chk("abort_err", 64'(bus.crc_err), 64'(0));
    chk_counters("abort");

    // frame_start ignored while crc_en is low in IDLE.
    bus.crc_en = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 24'($urandom));
    bus.ref_valid = 1'b1;
    tick();
    clr_in();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("disabled_no_done", 64'(bus.crc_done), 64'(0));
    end
    bus.crc_en = 1'b1;

    // Randomised frames.
    for (int f = 0; f < 14; f++) begin
      int n;
      logic [2:0] bad;
      n = $urandom_range(1, 6);
      rand_beats(n);
      bad = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run_frame($urandom_range(0, n), $urandom_range(0, 4), bad);
    end

    // Asynchronous reset mid-frame, after a mismatching frame left state behind.
    rand_beats(2);
    run_frame(2, 0, 3'b101);
    drive(1'b1, 1'b0, 1'b1, 24'($urandom));
    tick();
    drive(1'b0, 1'b0, 1'b1, 24'($urandom));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    clr_in();
    consec = 0;
    mcnt   = 0;
    scalar = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rand_beats(3);
    run_frame(4, 1, 3'b000);
    rand_beats(2);
    run_frame(0, 0, 3'b011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
